// File: rtl/pulse_burst_gen.sv
// rtl/pulse_burst_gen.sv - one start pulse in, a burst of COUNT timed on/off pulses out
// Durations are counted in 1 ms ticks from a free-running prescaler gated to the ON/OFF phases.
module pulse_burst_gen #(
    parameter int TICK_DIV = 100_000,
    parameter int MS_W     = 16,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    input  logic [MS_W-1:0]  i_on_ms,
    input  logic [MS_W-1:0]  i_off_ms,
    input  logic [CNT_W-1:0] i_count,
    output logic             o_out,
    output logic             o_busy,
    output logic             o_done
);
    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]    P_LAST = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0]    P_ONE  = PW'(1);
    localparam logic [MS_W-1:0]  MS_ONE = MS_W'(1);
    localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF, S_FIN} state_t;

    state_t           r_state;
    logic [PW-1:0]    r_presc;
    logic [MS_W-1:0]  r_ms;
    logic [MS_W-1:0]  r_on;
    logic [MS_W-1:0]  r_off;
    logic [CNT_W-1:0] r_rem;
    logic             r_out;
    logic             r_busy;
    logic             r_done;

    logic             w_tick;
    logic [MS_W-1:0]  w_ms_next;
    logic [MS_W-1:0]  w_on_cl;
    logic [MS_W-1:0]  w_off_cl;

    assign w_tick    = (r_presc == P_LAST);
    assign w_ms_next = r_ms + MS_ONE;
    // Zero durations become 1 ms so pulses stay distinct and the burst always progresses.
    assign w_on_cl   = (i_on_ms  == '0) ? MS_ONE : i_on_ms;
    assign w_off_cl  = (i_off_ms == '0) ? MS_ONE : i_off_ms;

    assign o_out  = r_out;
    assign o_busy = r_busy;
    assign o_done = r_done;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_presc <= '0;
            r_ms    <= '0;
            r_on    <= '0;
            r_off   <= '0;
            r_rem   <= '0;
            r_out   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_busy <= 1'b1;
                        if (i_count != '0) begin
                            r_on    <= w_on_cl;
                            r_off   <= w_off_cl;
                            r_rem   <= i_count;
                            r_presc <= '0;
                            r_ms    <= '0;
                            r_out   <= 1'b1;
                            r_state <= S_ON;
                        end else begin
                            r_state <= S_FIN;
                        end
                    end
                end
                S_ON: begin
                    if (w_tick) begin
                        r_presc <= '0;
                        if (w_ms_next == r_on) begin
                            r_ms    <= '0;
                            r_rem   <= r_rem - C_ONE;
                            r_out   <= 1'b0;
                            r_state <= (r_rem == C_ONE) ? S_FIN : S_OFF;
                        end else begin
                            r_ms <= w_ms_next;
                        end
                    end else begin
                        r_presc <= r_presc + P_ONE;
                    end
                end
                S_OFF: begin
                    if (w_tick) begin
                        r_presc <= '0;
                        if (w_ms_next == r_off) begin
                            r_ms    <= '0;
                            r_out   <= 1'b1;
                            r_state <= S_ON;
                        end else begin
                            r_ms <= w_ms_next;
                        end
                    end else begin
                        r_presc <= r_presc + P_ONE;
                    end
                end
                S_FIN: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pulse_burst_gen.sv
// tb/tb_pulse_burst_gen.sv - scoreboard bench for pulse_burst_gen
// Expected {out,busy,done} per cycle is queued at start time; a negedge monitor pops and compares.
module tb_pulse_burst_gen;
    localparam int TD    = 4;
    localparam int MS_W  = 16;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             i_start = 1'b0;
    logic [MS_W-1:0]  i_on_ms = '0;
    logic [MS_W-1:0]  i_off_ms = '0;
    logic [CNT_W-1:0] i_count = '0;
    logic             o_out;
    logic             o_busy;
    logic             o_done;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [2:0] exp_q[$];

    pulse_burst_gen #(.TICK_DIV(TD), .MS_W(MS_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .i_start(i_start), .i_on_ms(i_on_ms),
        .i_off_ms(i_off_ms), .i_count(i_count), .o_out(o_out),
        .o_busy(o_busy), .o_done(o_done)
    );

    always #5 clk = ~clk;

    // Reference: high time on*TD, low time off*TD, one trailing busy cycle, then done.
    task automatic push_expected(input int on, input int off, input int cnt);
        int on_c;
        int off_c;
        on_c  = (on  == 0) ? 1 : on;
        off_c = (off == 0) ? 1 : off;
        for (int p = 0; p < cnt; p++) begin
            for (int k = 0; k < on_c * TD; k++) exp_q.push_back(3'b110);
            if (p < cnt - 1)
                for (int k = 0; k < off_c * TD; k++) exp_q.push_back(3'b010);
        end
        exp_q.push_back(3'b010);
        exp_q.push_back(3'b001);
    endtask

    always @(negedge clk) begin
        logic [2:0] exp_v;
        cyc++;
        exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 3'b000;
        if (!reset) begin
            checks++;
            if ({o_out, o_busy, o_done} !== exp_v) begin
                failures++;
                $display("FAIL wave cyc=%0d got out/busy/done=%b required=%b",
                         cyc, {o_out, o_busy, o_done}, exp_v);
            end
        end
    end

    task automatic check(input string name, input logic got, input logic req);
        checks++;
        if (got !== req) begin
            failures++;
            $display("FAIL %s got=%b required=%b", name, got, req);
        end
    endtask

    // abort_at > 0 asserts reset that many cycles into the burst.
    task automatic burst(input int on, input int off, input int cnt,
                         input bit disturb, input int abort_at);
        int n;
        int c;
        @(posedge clk); #1;
        i_on_ms  = MS_W'(on);
        i_off_ms = MS_W'(off);
        i_count  = CNT_W'(cnt);
        i_start  = 1'b1;
        @(posedge clk);
        push_expected(on, off, cnt);
        n = exp_q.size();
        #1 i_start = 1'b0;
        c = 0;
        while (exp_q.size() > 0 && c < n + 10) begin
            @(posedge clk); #1;
            c++;
            if (disturb) begin
                i_start  = (c < n - 2) && ($urandom_range(0, 3) == 0);
                i_on_ms  = MS_W'($urandom_range(0, 7));
                i_off_ms = MS_W'($urandom_range(0, 7));
                i_count  = CNT_W'($urandom_range(0, 15));
            end
            if (abort_at > 0 && c == abort_at) begin
                #1 reset = 1'b1;
                exp_q.delete();
                #1 check("out_drops_on_reset", o_out, 1'b0);
                check("busy_drops_on_reset", o_busy, 1'b0);
                i_start = 1'b0;
                @(posedge clk); @(posedge clk); #1 reset = 1'b0;
            end
        end
        i_start = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL burst_timeout got pending=%0d required=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("reset_out", o_out, 1'b0);
        check("reset_busy", o_busy, 1'b0);
        check("reset_done", o_done, 1'b0);
        repeat (50) @(posedge clk);

        burst(3, 0, 1, 1'b0, 0);
        repeat (3) @(posedge clk);
        burst(2, 1, 3, 1'b0, 0);
        repeat (3) @(posedge clk);
        burst(5, 5, 0, 1'b0, 0);
        repeat (3) @(posedge clk);
        burst(0, 0, 2, 1'b0, 0);
        repeat (3) @(posedge clk);
        burst(2, 1, 2, 1'b1, 0);
        repeat (3) @(posedge clk);
        burst(2, 1, 3, 1'b0, 14);
        repeat (3) @(posedge clk);
        burst(2, 1, 3, 1'b0, 0);

        for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(1, 5)) @(posedge clk);
            burst($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 5),
                  1'($urandom_range(0, 1)), 0);
        end

        repeat (10) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
